// File: rtl/rb_mon_pkg.sv
// rb_mon_pkg: shared constants, types and saturating-increment helper for the ring buffer monitor.
package rb_mon_pkg;

    localparam int RB_DEPTH  = 8;
    localparam int RB_DATA_W = 16;
    localparam int RB_PTR_W  = 3;
    localparam int RB_CNT_W  = 16;

    typedef logic [15:0] rb_data_t;
    typedef logic [2:0]  rb_ptr_t;

    // Works on counters up to 32 bits wide; w is the live width of v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] all_ones;
        all_ones = (32'd1 << w) - 32'd1;
        return (v == all_ones) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rb_shadow_mem.sv
// rb_shadow_mem: shadow copy of the ring buffer contents with per-entry valid bits and write pointer.
module rb_shadow_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [PTR_W-1:0]  wr_ptr
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    always_ff @(posedge clk)
        if (!reset && cap)
            mem[wr_ptr] <= din;

    // Pointer wraps naturally because DEPTH is 2**PTR_W.
    always_ff @(posedge clk)
        if (reset) begin
            valid  <= '0;
            wr_ptr <= '0;
        end else if (cap) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
        end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = valid[rd_ptr];

endmodule

// File: rtl/ring_buffer_monitor.sv
// ring_buffer_monitor: checks ring buffer dout against a shadow copy and counts mismatches.
// Define RB_MON_DISPLAY_EN to print each failed check and a final summary in simulation.
module ring_buffer_monitor import rb_mon_pkg::*; #(
    parameter int DEPTH  = RB_DEPTH,
    parameter int DATA_W = RB_DATA_W,
    parameter int PTR_W  = RB_PTR_W,
    parameter int CNT_W  = RB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              listen,
    input  logic              strobe,
    input  logic [DATA_W-1:0] din,
    input  logic [PTR_W-1:0]  readPtr,
    input  logic [DATA_W-1:0] dout,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  check_count,
    output logic [PTR_W-1:0]  last_err_ptr,
    output logic [PTR_W-1:0]  wr_ptr
);

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              fail;

    rb_shadow_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .cap      (listen && strobe),
        .din      (din),
        .rd_ptr   (readPtr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_ptr   (wr_ptr)
    );

    // Case inequality so X/Z on dout for a valid entry is flagged.
    assign fail = rd_valid && (dout !== rd_data);

    always_ff @(posedge clk)
        if (reset) begin
            mismatch     <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            check_count  <= '0;
            last_err_ptr <= '0;
        end else begin
            mismatch <= fail;
            if (rd_valid)
                check_count <= CNT_W'(sat_inc(32'(check_count), CNT_W));
            if (fail) begin
                err_sticky   <= 1'b1;
                err_count    <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                last_err_ptr <= readPtr;
            end
        end

`ifdef RB_MON_DISPLAY_EN
    always @(posedge clk)
        if (!reset && fail)
            $display("%0t rb_mon: readPtr=%0d expected=%h actual=%h", $time, readPtr, rd_data, dout);

    final
        $display("rb_mon: check_count=%0d err_count=%0d", check_count, err_count);
`else
`endif

endmodule

// File: tb/tb_ring_buffer_monitor.sv
// tb_ring_buffer_monitor: directed vectors with hand-computed expectations for ring_buffer_monitor.
module tb_ring_buffer_monitor;

    logic        clk = 1'b0;
    logic        reset, listen, strobe;
    logic [15:0] din, dout;
    logic [2:0]  readPtr;
    logic        mismatch, err_sticky;
    logic [15:0] err_count, check_count;
    logic [2:0]  last_err_ptr, wr_ptr;

    int vectors = 0;
    int miscompares = 0;

    ring_buffer_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .listen       (listen),
        .strobe       (strobe),
        .din          (din),
        .readPtr      (readPtr),
        .dout         (dout),
        .mismatch     (mismatch),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .check_count  (check_count),
        .last_err_ptr (last_err_ptr),
        .wr_ptr       (wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_mismatch"}, 32'(mismatch), 0);
        check({tag, "_sticky"},   32'(err_sticky), 0);
        check({tag, "_errcnt"},   32'(err_count), 0);
        check({tag, "_chkcnt"},   32'(check_count), 0);
        check({tag, "_lastptr"},  32'(last_err_ptr), 0);
        check({tag, "_wrptr"},    32'(wr_ptr), 0);
    endtask

    initial begin
        reset = 1; listen = 0; strobe = 0; din = 0; dout = 0; readPtr = 5;
        step(); step();
        reset = 0;
        check_cleared("reset");

        listen = 1; strobe = 1;
        din = 16'h1111; step();
        din = 16'h2222; step();
        din = 16'h3333; step();
        strobe = 0;
        check("fill_wrptr", 32'(wr_ptr), 3);
        check("fill_chkcnt", 32'(check_count), 0);

        readPtr = 0; dout = 16'h1111; step();
        check("rd0_mismatch", 32'(mismatch), 0);
        readPtr = 1; dout = 16'h2222; step();
        check("rd1_mismatch", 32'(mismatch), 0);
        readPtr = 2; dout = 16'h3333; step();
        check("rd2_mismatch", 32'(mismatch), 0);
        check("rd_chkcnt", 32'(check_count), 3);

        readPtr = 5; dout = 16'hDEAD; step();
        check("invalid_chkcnt", 32'(check_count), 3);
        check("invalid_sticky", 32'(err_sticky), 0);
        check("invalid_errcnt", 32'(err_count), 0);

        readPtr = 1; dout = 16'h2223; step();
        check("err_mismatch", 32'(mismatch), 1);
        check("err_errcnt", 32'(err_count), 1);
        check("err_lastptr", 32'(last_err_ptr), 1);
        check("err_sticky", 32'(err_sticky), 1);
        check("err_chkcnt", 32'(check_count), 4);
        readPtr = 5; dout = 16'h0000; step();
        check("pulse_end", 32'(mismatch), 0);
        check("sticky_hold", 32'(err_sticky), 1);
        check("errcnt_hold", 32'(err_count), 1);

        reset = 1; step();
        reset = 0;
        check_cleared("rst2");
        readPtr = 1; dout = 16'h0000; step();
        check("rst2_valid_clr", 32'(check_count), 0);
        listen = 0; strobe = 1; din = 16'hABCD; step();
        check("nolisten_wrptr", 32'(wr_ptr), 0);
        readPtr = 0; step();
        check("nolisten_chkcnt", 32'(check_count), 0);
        strobe = 0;

        listen = 1; strobe = 1; readPtr = 7; dout = 16'h0007;
        for (int i = 0; i < 9; i++) begin
            din = 16'(i);
            step();
        end
        strobe = 0;
        check("wrap_wrptr", 32'(wr_ptr), 1);
        check("wrap_chkcnt", 32'(check_count), 1);
        readPtr = 0; dout = 16'h0000; step();
        check("wrap_old_mismatch", 32'(mismatch), 1);
        check("wrap_errcnt", 32'(err_count), 1);
        check("wrap_lastptr", 32'(last_err_ptr), 0);
        dout = 16'h0008; step();
        check("wrap_new_mismatch", 32'(mismatch), 0);
        check("wrap_chkcnt2", 32'(check_count), 3);

        readPtr = 7; dout = 16'h0007; strobe = 1; din = 16'hAAAA; step();
        check("same_pre_wrptr", 32'(wr_ptr), 2);
        readPtr = 2; dout = 16'h0002; din = 16'hBBBB; step();
        check("same_edge_mismatch", 32'(mismatch), 0);
        check("same_edge_wrptr", 32'(wr_ptr), 3);
        check("same_edge_chkcnt", 32'(check_count), 5);
        strobe = 0; step();
        check("same_next_mismatch", 32'(mismatch), 1);
        check("same_next_errcnt", 32'(err_count), 2);
        check("same_next_lastptr", 32'(last_err_ptr), 2);
        dout = 16'hBBBB; step();
        check("same_new_ok", 32'(mismatch), 0);
        check("same_new_chkcnt", 32'(check_count), 7);
        check("same_new_errcnt", 32'(err_count), 2);
        check("same_new_sticky", 32'(err_sticky), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
